// File: rtl/hermes_adc_scan.sv
// hermes_adc_scan: round-robin SPI scanner for the ADC78H90 8-channel 12-bit ADC.
// Each 16-bit frame sends the channel pointer in bits [13:11]. The word returned in
// the same frame belongs to the address sent in the previous frame. A full sweep is
// copied to ain as one coherent snapshot, flagged by a one-cycle ain_valid pulse.
// Optional feature macro: ADC_PEAK_HOLD_EN (per-channel peak hold for channels set in
// PEAK_MASK, with a four-phase pk_detect_reset/pk_detect_ack handshake).
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   scan_enable           level; high = sweep continuously
//   SCLK, nCS, MOSI       ADC serial clock, chip select (active low), control word out
//   MISO                  ADC conversion data in
//   ain[12*NUM_CH-1:0]    snapshot; channel i at [12i+11:12i]
//   ain_valid             one-cycle strobe when a new snapshot is on ain
//   pk_detect_reset       peak-interval restart request (level, synchronous to clock)
//   pk_detect_ack         acknowledge of pk_detect_reset
module hermes_adc_scan #(
    parameter int unsigned NUM_CH    = 6,
    parameter int unsigned SCLK_DIV  = 2,
    parameter logic [7:0]  PEAK_MASK = 8'b0000_0011
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  scan_enable,
    output logic                  SCLK,
    output logic                  nCS,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [12*NUM_CH-1:0]  ain,
    output logic                  ain_valid,
    input  logic                  pk_detect_reset,
    output logic                  pk_detect_ack
);

    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DW = $clog2(2 * SCLK_DIV + 1);
    localparam int unsigned SW = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_HIGH,
        S_BIT_LO,
        S_BIT_HI,
        S_STORE
    } state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      prev_q, prev_d;
    logic               prev_vld_q, prev_vld_d;
    logic [SW-1:0]      shift_q, shift_d;
    logic               sclk_q, sclk_d;
    logic               ncs_q, ncs_d;
    logic               mosi_q, mosi_d;
    logic [12*NUM_CH-1:0] ain_q, ain_d;
    logic               ain_vld_q, ain_vld_d;
    logic [SW-1:0]      samp_q [NUM_CH];
    logic [SW-1:0]      samp_d [NUM_CH];
    logic [15:0]        ctrl_word;
    logic               wr_en;
    logic               snap;

    assign ctrl_word = {2'b00, 3'(ptr_q), 11'h000};

    // Frame sequencer: next state, bit/divider counters, pointer bookkeeping, pin levels
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        ptr_d      = ptr_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        shift_d    = shift_q;
        wr_en      = 1'b0;
        snap       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (scan_enable) begin
                    state_d    = S_CS_HIGH;
                    div_d      = '0;
                    ptr_d      = '0;
                    prev_vld_d = 1'b0;
                end
            end
            S_CS_HIGH: begin
                if (div_q == DW'(2 * SCLK_DIV - 1)) begin
                    state_d = S_BIT_LO;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_BIT_LO: begin
                if (div_q == DW'(SCLK_DIV - 1)) begin
                    state_d = S_BIT_HI;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_BIT_HI: begin
                if (div_q == DW'(SCLK_DIV - 1)) begin
                    // Only the low 12 received bits survive; the 4 leading zeros shift out.
                    shift_d = {shift_q[SW-2:0], MISO};
                    div_d   = '0;
                    if (bit_q == 4'd15) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_BIT_LO;
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_STORE: begin
                // Returned data belongs to the previous frame's address.
                wr_en      = prev_vld_q;
                snap       = prev_vld_q && (prev_q == PW'(NUM_CH - 1));
                prev_vld_d = 1'b1;
                prev_d     = ptr_q;
                ptr_d      = (ptr_q == PW'(NUM_CH - 1)) ? '0 : ptr_q + PW'(1);
                div_d      = '0;
                state_d    = scan_enable ? S_CS_HIGH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        sclk_d = (state_d == S_BIT_HI);
        ncs_d  = !((state_d == S_BIT_LO) || (state_d == S_BIT_HI));
        mosi_d = ncs_d ? 1'b0 : ctrl_word[4'd15 - bit_d];
    end

    // Per-channel sample registers
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            samp_d[i] = samp_q[i];
            if (wr_en && (prev_q == PW'(i))) begin
                samp_d[i] = shift_q;
            end
        end
    end

`ifdef ADC_PEAK_HOLD_EN
    logic [SW-1:0] peak_q [NUM_CH];
    logic [SW-1:0] peak_d [NUM_CH];
    logic          ack_q, ack_d;
    logic          reload;

    // Peak tracking; a handshake reload at a snapshot overrides the running max
    always_comb begin
        reload = snap && pk_detect_reset && !ack_q;
        for (int i = 0; i < NUM_CH; i++) begin
            peak_d[i] = peak_q[i];
            if (PEAK_MASK[i]) begin
                if (reload) begin
                    peak_d[i] = samp_d[i];
                end else if (wr_en && (prev_q == PW'(i)) && (shift_q > peak_q[i])) begin
                    peak_d[i] = shift_q;
                end
            end
        end
        ack_d = ack_q;
        if (reload) begin
            ack_d = 1'b1;
        end else if (ack_q && !pk_detect_reset) begin
            ack_d = 1'b0;
        end
        ain_d = ain_q;
        if (snap) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ain_d[12*i +: 12] = PEAK_MASK[i] ? peak_d[i] : samp_d[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                peak_q[i] <= '0;
            end
            ack_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                peak_q[i] <= peak_d[i];
            end
            ack_q <= ack_d;
        end
    end

    assign pk_detect_ack = ack_q;
`else
    logic unused_pk;

    // Snapshot of raw samples
    always_comb begin
        ain_d = ain_q;
        if (snap) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ain_d[12*i +: 12] = samp_d[i];
            end
        end
    end

    assign unused_pk     = pk_detect_reset ^ PEAK_MASK[0];
    assign pk_detect_ack = 1'b0;
`endif

    assign ain_vld_d = snap;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            ptr_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            shift_q    <= '0;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            mosi_q     <= 1'b0;
            ain_q      <= '0;
            ain_vld_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                samp_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            ptr_q      <= ptr_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            shift_q    <= shift_d;
            sclk_q     <= sclk_d;
            ncs_q      <= ncs_d;
            mosi_q     <= mosi_d;
            ain_q      <= ain_d;
            ain_vld_q  <= ain_vld_d;
            for (int i = 0; i < NUM_CH; i++) begin
                samp_q[i] <= samp_d[i];
            end
        end
    end

    assign SCLK      = sclk_q;
    assign nCS       = ncs_q;
    assign MOSI      = mosi_q;
    assign ain       = ain_q;
    assign ain_valid = ain_vld_q;

endmodule

// File: tb/tb_hermes_adc_scan.sv
// Bench for hermes_adc_scan: instance A uses default parameters, instance B uses
// NUM_CH=8, SCLK_DIV=1. Each instance talks to a small ADC78H90 behavioural model
// that returns the value of the address received in the previous frame.
module tb_hermes_adc_scan;

`ifdef ADC_PEAK_HOLD_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en_a, en_b, pkr;
    logic sclk_a, ncs_a, mosi_a, miso_a = 1'b0;
    logic [71:0] ain_a;
    logic vld_a, ack_a;
    logic sclk_b, ncs_b, mosi_b, miso_b = 1'b0;
    logic [95:0] ain_b;
    logic vld_b, ack_b;

    int checks = 0;
    int errors = 0;

    hermes_adc_scan u_a (
        .clock(clk), .reset_n(rst_n), .scan_enable(en_a),
        .SCLK(sclk_a), .nCS(ncs_a), .MOSI(mosi_a), .MISO(miso_a),
        .ain(ain_a), .ain_valid(vld_a),
        .pk_detect_reset(pkr), .pk_detect_ack(ack_a)
    );

    hermes_adc_scan #(.NUM_CH(8), .SCLK_DIV(1)) u_b (
        .clock(clk), .reset_n(rst_n), .scan_enable(en_b),
        .SCLK(sclk_b), .nCS(ncs_b), .MOSI(mosi_b), .MISO(miso_b),
        .ain(ain_b), .ain_valid(vld_b),
        .pk_detect_reset(1'b0), .pk_detect_ack(ack_b)
    );

    // ADC model A
    logic [11:0] val_a [8];
    logic [15:0] tx_a = 16'h0, rx_a = 16'h0;
    logic [2:0]  padr_a = 3'd0;
    int bc_a = 0, sc_a = 0, last_sc_a = 0;
    logic [15:0] words_a [$];
    always @(negedge ncs_a) begin
        tx_a = {4'h0, val_a[padr_a]}; bc_a = 0; sc_a = 0; miso_a = tx_a[15];
    end
    always @(posedge sclk_a) begin rx_a = {rx_a[14:0], mosi_a}; sc_a++; end
    always @(negedge sclk_a) begin bc_a++; if (bc_a < 16) miso_a = tx_a[15-bc_a]; end
    always @(posedge ncs_a) begin padr_a = rx_a[13:11]; last_sc_a = sc_a; words_a.push_back(rx_a); end

    // ADC model B
    logic [11:0] val_b [8];
    logic [15:0] tx_b = 16'h0, rx_b = 16'h0;
    logic [2:0]  padr_b = 3'd0;
    int bc_b = 0;
    logic [15:0] words_b [$];
    always @(negedge ncs_b) begin
        tx_b = {4'h0, val_b[padr_b]}; bc_b = 0; miso_b = tx_b[15];
    end
    always @(posedge sclk_b) rx_b = {rx_b[14:0], mosi_b};
    always @(negedge sclk_b) begin bc_b++; if (bc_b < 16) miso_b = tx_b[15-bc_b]; end
    always @(posedge ncs_b) begin padr_b = rx_b[13:11]; words_b.push_back(rx_b); end

    // Counts clock edges until the selected ain_valid is seen; -1 on timeout.
    task automatic wait_vld(input bit sel_b, input int max, output int n);
        n = 0;
        while (n < max) begin
            @(posedge clk); #1;
            n++;
            if ((sel_b ? vld_b : vld_a) === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; pkr = 1'b0;
        for (int i = 0; i < 8; i++) begin val_a[i] = 12'h100 + 12'(i); val_b[i] = 12'h0; end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk_a); end
        checks++; if (ncs_a !== 1'b1) begin errors++; $display("FAIL reset_ncs got %b want 1", ncs_a); end
        checks++; if (mosi_a !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi_a); end
        checks++; if (ain_a !== 72'h0) begin errors++; $display("FAIL reset_ain got %h want 0", ain_a); end
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", vld_a); end
        checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack_a); end
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (ncs_a !== 1'b1 || sclk_a !== 1'b0) begin
            errors++; $display("FAIL idle_pins got ncs=%b sclk=%b want ncs=1 sclk=0", ncs_a, sclk_a);
        end
    endtask

    task automatic test_sweep();
        int n;
        logic [71:0] exp;
        logic [15:0] wexp;
        for (int i = 0; i < 6; i++) exp[12*i +: 12] = 12'h100 + 12'(i);
        words_a.delete();
        en_a = 1'b1;
        wait_vld(1'b0, 2000, n);
        checks++; if (n != 484) begin errors++; $display("FAIL sweep_first_latency got %0d want 484", n); end
        checks++; if (ain_a !== exp) begin errors++; $display("FAIL sweep_ain got %h want %h", ain_a, exp); end
        @(posedge clk); #1;
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL sweep_valid_width got %b want 0", vld_a); end
        wait_vld(1'b0, 2000, n);
        checks++; if (n != 413) begin errors++; $display("FAIL sweep_period got %0d want 413", n); end
        checks++; if (ain_a !== exp) begin errors++; $display("FAIL sweep_ain2 got %h want %h", ain_a, exp); end
        checks++;
        if (words_a.size() < 12) begin
            errors++; $display("FAIL sweep_word_count got %0d want >=12", words_a.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                wexp = {2'b00, 3'(k % 6), 11'h000};
                checks++;
                if (words_a[k] !== wexp) begin
                    errors++; $display("FAIL ctrl_word_%0d got %h want %h", k, words_a[k], wexp);
                end
            end
        end
    endtask

    task automatic test_peak();
        int n;
        logic [11:0] e0;
        val_a[0] = 12'h300;
        wait_vld(1'b0, 2000, n); wait_vld(1'b0, 2000, n);
        checks++; if (ain_a[11:0] !== 12'h300) begin errors++; $display("FAIL peak_rise got %h want 300", ain_a[11:0]); end
        val_a[0] = 12'h200;
        wait_vld(1'b0, 2000, n); wait_vld(1'b0, 2000, n);
        e0 = PEAK ? 12'h300 : 12'h200;
        checks++; if (ain_a[11:0] !== e0) begin errors++; $display("FAIL peak_hold got %h want %h", ain_a[11:0], e0); end
        checks++; if (ain_a[35:24] !== 12'h102) begin errors++; $display("FAIL peak_raw_ch2 got %h want 102", ain_a[35:24]); end
        pkr = 1'b1;
        @(posedge clk); #1;
        checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL ack_early got %b want 0", ack_a); end
        wait_vld(1'b0, 2000, n);
        checks++; if (ack_a !== PEAK) begin errors++; $display("FAIL ack_at_snapshot got %b want %b", ack_a, PEAK); end
        checks++; if (ain_a[11:0] !== 12'h200) begin errors++; $display("FAIL peak_reload got %h want 200", ain_a[11:0]); end
        checks++; if (ain_a[23:12] !== 12'h101) begin errors++; $display("FAIL peak_reload_ch1 got %h want 101", ain_a[23:12]); end
        pkr = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL ack_drop got %b want 0", ack_a); end
    endtask

    task automatic test_disable();
        int n, lows, highs;
        logic [71:0] exp;
        n = 0;
        while (!(ncs_a === 1'b0 && sclk_a === 1'b1) && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (n >= 300) begin errors++; $display("FAIL dis_find_bit got timeout want mid-frame"); end
        en_a = 1'b0;
        n = 0;
        while (ncs_a !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (n >= 300) begin errors++; $display("FAIL dis_frame_end got timeout want nCS high"); end
        checks++; if (last_sc_a != 16) begin errors++; $display("FAIL dis_frame_bits got %0d want 16", last_sc_a); end
        lows = 0; highs = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (ncs_a !== 1'b1) lows++;
            if (sclk_a !== 1'b0) highs++;
        end
        checks++; if (lows != 0 || highs != 0) begin
            errors++; $display("FAIL dis_idle got ncs_low=%0d sclk_high=%0d want 0 0", lows, highs);
        end
        for (int i = 0; i < 6; i++) begin val_a[i] = 12'h500 + 12'(i); exp[12*i +: 12] = 12'h500 + 12'(i); end
        words_a.delete();
        en_a = 1'b1;
        wait_vld(1'b0, 2000, n);
        checks++; if (n != 484) begin errors++; $display("FAIL reen_latency got %0d want 484", n); end
        checks++; if (ain_a !== exp) begin errors++; $display("FAIL reen_ain got %h want %h", ain_a, exp); end
        checks++; if (words_a.size() < 1 || words_a[0] !== 16'h0000) begin
            errors++; $display("FAIL reen_first_word got %h want 0000", (words_a.size() > 0) ? words_a[0] : 16'hxxxx);
        end
    endtask

    task automatic test_fast();
        int n;
        logic [95:0] exp;
        logic [15:0] wexp;
        for (int i = 0; i < 8; i++) begin
            val_b[i] = 12'hA00 + 12'(i * 17); exp[12*i +: 12] = 12'hA00 + 12'(i * 17);
        end
        words_b.delete();
        en_b = 1'b1;
        wait_vld(1'b1, 2000, n);
        checks++; if (n != 316) begin errors++; $display("FAIL fast_latency got %0d want 316", n); end
        checks++; if (ain_b !== exp) begin errors++; $display("FAIL fast_ain got %h want %h", ain_b, exp); end
        checks++; if (ack_b !== 1'b0) begin errors++; $display("FAIL fast_ack got %b want 0", ack_b); end
        @(posedge clk); #1;
        wait_vld(1'b1, 2000, n);
        checks++; if (n != 279) begin errors++; $display("FAIL fast_period got %0d want 279", n); end
        for (int k = 0; k < 9; k++) begin
            wexp = {2'b00, 3'(k % 8), 11'h000};
            checks++;
            if (words_b.size() <= k || words_b[k] !== wexp) begin
                errors++; $display("FAIL fast_word_%0d got %h want %h", k, (words_b.size() > k) ? words_b[k] : 16'hxxxx, wexp);
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [71:0] exp;
        for (int i = 0; i < 6; i++) begin val_a[i] = 12'h0C0 + 12'(i); exp[12*i +: 12] = 12'h0C0 + 12'(i); end
        n = 0;
        while (sclk_a !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (n >= 300) begin errors++; $display("FAIL rmid_find_bit got timeout want SCLK high"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sclk_a !== 1'b0 || ncs_a !== 1'b1 || mosi_a !== 1'b0) begin
            errors++; $display("FAIL rmid_pins got sclk=%b ncs=%b mosi=%b want 0 1 0", sclk_a, ncs_a, mosi_a);
        end
        checks++; if (ain_a !== 72'h0 || vld_a !== 1'b0) begin
            errors++; $display("FAIL rmid_ain got %h valid=%b want 0 0", ain_a, vld_a);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_vld(1'b0, 2000, n);
        checks++; if (n != 484) begin errors++; $display("FAIL rmid_latency got %0d want 484", n); end
        checks++; if (ain_a !== exp) begin errors++; $display("FAIL rmid_ain_after got %h want %h", ain_a, exp); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_peak();
        test_disable();
        test_fast();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hermes_adc_scan.md
# hermes_adc_scan

Parametrised SPI scanner for the ADC78H90 8-channel 12-bit converter, successor to the fixed six-channel Hermes ADC poller. Sweeps a configurable number of channels round-robin, attributes each returned word to the address sent in the *previous* frame, and presents a coherent per-sweep snapshot of all channels. Optional per-channel peak hold uses a four-phase reset/acknowledge handshake with the Tx FIFO control logic. Sits between the board ADC pins and the telemetry/PA-protection logic.

## Interface
- NUM_CH, 6: channels scanned, 1..8; channel i uses ADC address i.
- SCLK_DIV, 2: clock cycles per SCLK half-period, ≥1; SCLK = clock/(2·SCLK_DIV).
- PEAK_MASK, 8'b0000_0011: bit i set = channel i reports peak-hold value (only with peak hold compiled in).

- clock  in  1  system clock, 30.72 MHz nominal.
- reset_n  in  1  asynchronous, active-low reset.
- scan_enable  in  1  level; high = sweep continuously.
- SCLK  out  1  ADC serial clock.
- nCS  out  1  ADC chip select, active low.
- MOSI  out  1  control word to ADC.
- MISO  in  1  conversion data from ADC.
- ain  out  12·NUM_CH  channel i at bits [12i+11:12i].
- ain_valid  out  1  one-cycle strobe, new snapshot on ain.
- pk_detect_reset  in  1  peak-interval restart request (level).
- pk_detect_ack  out  1  acknowledge of pk_detect_reset.

## Operation
- Reset values: SCLK 0, nCS 1, MOSI 0, ain 0, ain_valid 0, pk_detect_ack 0; channel pointer 0; "previous address valid" flag cleared.
- States: IDLE → CS_HIGH → BIT_LO → BIT_HI → (next bit or STORE) → CS_HIGH …
- IDLE: nCS 1, SCLK 0. Leave when scan_enable=1; pointer set to 0, prev-valid cleared.
- CS_HIGH: nCS 1 for 2·SCLK_DIV cycles, then nCS 0 and first bit.
- Control word: 16 bits MSB first, bits[13:11] = channel pointer, all others 0.
- BIT_LO: MOSI driven with current bit, SCLK 0 for SCLK_DIV cycles. BIT_HI: SCLK 1 for SCLK_DIV cycles; MISO sampled on last clock of BIT_HI.
- Received 16 bits: bits[15:12] ignored, bits[11:0] = sample MSB first.
- STORE (one cycle, SCLK 0, nCS 1): if prev-valid, sample written to sample register of the previous frame's address; prev-valid set; previous-address register ← current pointer; pointer increments, wraps NUM_CH-1 → 0.
- Snapshot: STORE that writes channel NUM_CH-1 copies all channel values to ain and pulses ain_valid next cycle.
- First frame after reset or re-enable: data discarded; no write.
- scan_enable low: current frame completes including STORE, then IDLE. Re-enable restarts at channel 0 with discard.
- NUM_CH=1: every frame addresses channel 0; ain_valid once per frame after the first.
- Reset asserted mid-frame: all outputs to reset values immediately; partial word discarded.

## Timing
- Frame length 34·SCLK_DIV + 1 clocks (default 69; SCLK 7.68 MHz).
- Sweep period NUM_CH frames; first ain_valid after (NUM_CH+1) frames from enable.
- ain stable between strobes; ain_valid exactly one cycle wide.
- pk_detect_reset synchronous to clock; no synchroniser inside.

## Configuration
- ADC_PEAK_HOLD_EN defined: per masked channel, peak register ← max(peak, sample) at every write; ain carries peak for masked channels, raw sample otherwise. At a snapshot with pk_detect_reset=1 and pk_detect_ack=0: masked peaks reloaded with the newest sample (reload wins over max), ack ← 1. ack ← 0 on the cycle after pk_detect_reset sampled 0. No further reloads while ack=1.
- Undefined: PEAK_MASK ignored, ain = raw samples, pk_detect_ack constant 0, pk_detect_reset unused.

## Test plan
- Default params, ADC model returns 12'h100+address: after 7 frames ain = {105,104,103,102,101,100}h, ain_valid one cycle; control words 0x0000,0x0800…0x2800 repeating.
- SCLK_DIV=1, NUM_CH=8: frame 35 clocks, SCLK 15.36 MHz, MISO sampled in SCLK-high cycle, all 8 channels correct.
- Peak hold: ch0 returns 0x300 then 0x200: ain ch0 stays 0x300; raise pk_detect_reset → ack 1 at next snapshot, ch0 reads 0x200; drop reset → ack 0 next cycle.
- Without ADC_PEAK_HOLD_EN: same stimulus → ch0 follows 0x200, ack stays 0.
- scan_enable low mid-frame: frame finishes, nCS stays 1; re-enable → first word discarded, pointer starts at 0.
- reset_n low mid-bit: SCLK 0, nCS 1, ain 0 same cycle; first ain_valid after (NUM_CH+1) frames post-release.
